// File: rtl/pulsed_decoder_pkg.sv
//==============================================================================
// Module : pulsed_decoder_pkg
// Brief  : Shared state encoding, mode constants and counter sizing helper.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pulsed_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  // Strobe counter width: max(1, clog2(len)).
  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulsed_decoder_if.sv
//==============================================================================
// Module : pulsed_decoder_if
// Brief  : Request handshake and decoded-output bundle for pulsed_decoder.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pulsed_decoder_if #(
  parameter int SEL_W = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic                    mode;
  logic                    clr;
  logic [(1<<SEL_W)-1:0]   dout;
  logic                    busy;
  logic                    done;

  modport master (
    output in_valid, in_sel, mode, clr,
    input  in_ready, dout, busy, done
  );

  modport slave (
    input  in_valid, in_sel, mode, clr,
    output in_ready, dout, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/pulsed_decoder_onehot_decode.sv
//==============================================================================
// Module : onehot_decode
// Brief  : Combinational binary-to-one-hot decoder, 2^SEL_W lines.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module onehot_decode #(
  parameter int SEL_W = 2
) (
  input  wire logic [SEL_W-1:0]      i_sel,
  output logic      [(1<<SEL_W)-1:0] o_onehot
);
  localparam int N_LINES = 1 << SEL_W;

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
    assign o_onehot[gi] = (i_sel == SEL_W'(gi));
  end
endmodule

`default_nettype wire

// File: rtl/pulsed_decoder.sv
//==============================================================================
// Module : pulsed_decoder
// Brief  : Registered one-hot decoder with valid/ready input, pulse/level modes.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pulsed_decoder
  import pulsed_decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int PULSE_LEN  = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  pulsed_decoder_if.slave bus
);
  localparam int                   N_LINES   = 1 << SEL_W;
  localparam int                   CNT_W     = cnt_width(PULSE_LEN);
  localparam logic [N_LINES-1:0]   DOUT_IDLE = {N_LINES{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(PULSE_LEN - 1);

  state_t               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_LINES-1:0]   r_dout;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic [SEL_W-1:0]     w_sel_next;
  logic [N_LINES-1:0]   w_onehot;
  logic [N_LINES-1:0]   w_dout_on;

  // clr beats a concurrent request in every state.
  assign w_accept   = bus.in_valid && (r_state != PULSE) && !bus.clr;

  // Decode the select the latch is about to hold, so dout changes on the
  // accepting edge itself rather than one cycle later.
  assign w_sel_next = w_accept ? bus.in_sel : r_sel;

  onehot_decode #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel    (w_sel_next),
    .o_onehot (w_onehot)
  );

  assign w_dout_on = w_onehot ^ DOUT_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_dout  <= DOUT_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if ((r_state == HOLD) && bus.clr) begin
            r_state <= IDLE;
            r_dout  <= DOUT_IDLE;
          end else if (w_accept) begin
            r_sel  <= bus.in_sel;
            r_dout <= w_dout_on;
            if (bus.mode == MODE_PULSE) begin
              r_state <= PULSE;
              r_cnt   <= CNT_LOAD;
              r_busy  <= 1'b1;
              r_done  <= (CNT_LOAD == '0);
            end else begin
              r_state <= HOLD;
            end
          end
        end
        PULSE: begin
          if (bus.clr || (r_cnt == '0)) begin
            r_state <= IDLE;
            r_dout  <= DOUT_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: begin
          r_state <= IDLE;
          r_dout  <= DOUT_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Reset must hold in_ready low even though the state already reads IDLE.
  assign bus.in_ready = rst_n && (r_state != PULSE);
  assign bus.dout     = r_dout;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

`default_nettype wire

// File: tb/tb_pulsed_decoder.sv
//==============================================================================
// Module : tb_pulsed_decoder
// Brief  : Self-checking bench for three pulsed_decoder configurations.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pulsed_decoder;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1, rst_n2;

  pulsed_decoder_if #(.SEL_W(2)) if0 ();
  pulsed_decoder_if #(.SEL_W(2)) if1 ();
  pulsed_decoder_if #(.SEL_W(4)) if2 ();

  pulsed_decoder #(.SEL_W(2), .PULSE_LEN(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n0), .bus(if0));
  pulsed_decoder #(.SEL_W(2), .PULSE_LEN(4), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n1), .bus(if1));
  pulsed_decoder #(.SEL_W(4), .PULSE_LEN(1), .ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n2), .bus(if2));

  function automatic int pl(input int i); return (i == 2) ? 1 : 4; endfunction
  function automatic int sw(input int i); return (i == 2) ? 4 : 2; endfunction
  function automatic bit al(input int i); return (i == 1); endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit v [NI];
  bit md[NI];
  bit cl[NI];
  int s [NI];

  // Reference: which line is lit (-1 = none) and pulse cycles still to show.
  int m_line[NI];
  int m_left[NI];

  function automatic bit rst_of(input int i);
    return (i == 0) ? rst_n0 : (i == 1) ? rst_n1 : rst_n2;
  endfunction

  function automatic logic [15:0] exp_dout(input int i);
    logic [15:0] d;
    logic [15:0] mask;
    d    = 16'd0;
    mask = 16'((32'd1 << (1 << sw(i))) - 32'd1);
    if (m_line[i] >= 0) d[m_line[i]] = 1'b1;
    if (al(i)) d = ~d & mask;
    return d;
  endfunction

  task automatic apply();
    if0.in_valid = v[0]; if0.in_sel = 2'(s[0]); if0.mode = md[0]; if0.clr = cl[0];
    if1.in_valid = v[1]; if1.in_sel = 2'(s[1]); if1.mode = md[1]; if1.clr = cl[1];
    if2.in_valid = v[2]; if2.in_sel = 4'(s[2]); if2.mode = md[2]; if2.clr = cl[2];
  endtask

  task automatic model_step(input int i);
    bit accept;
    if (!rst_of(i)) begin
      m_line[i] = -1;
      m_left[i] = 0;
      return;
    end
    accept = v[i] && (m_left[i] == 0) && !cl[i];
    if (cl[i] && (m_line[i] >= 0)) begin
      m_line[i] = -1;
      m_left[i] = 0;
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) m_line[i] = -1;
    end else if (accept) begin
      m_line[i] = s[i];
      m_left[i] = md[i] ? 0 : pl(i);
    end
  endtask

  task automatic check_all();
    logic [15:0] dv[NI];
    bit rd[NI], bz[NI], dn[NI];
    dv[0] = 16'(if0.dout); rd[0] = if0.in_ready; bz[0] = if0.busy; dn[0] = if0.done;
    dv[1] = 16'(if1.dout); rd[1] = if1.in_ready; bz[1] = if1.busy; dn[1] = if1.done;
    dv[2] = 16'(if2.dout); rd[2] = if2.in_ready; bz[2] = if2.busy; dn[2] = if2.done;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.dout", i),  32'(dv[i]), 32'(exp_dout(i)));
      check($sformatf("u%0d.ready", i), 32'(rd[i]), 32'(rst_of(i) && (m_left[i] == 0)));
      check($sformatf("u%0d.busy", i),  32'(bz[i]), 32'(m_left[i] > 0));
      check($sformatf("u%0d.done", i),  32'(dn[i]), 32'(m_left[i] == 1));
    end
  endtask

  task automatic tick();
    apply();
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NI; i++) begin
      v[i] = 1'b0; md[i] = 1'b0; cl[i] = 1'b0; s[i] = 0;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NI; i++) begin
      v[i]  = 1'($urandom_range(0, 1));
      md[i] = 1'($urandom_range(0, 1));
      cl[i] = ($urandom_range(0, 9) == 0);
      s[i]  = int'($urandom_range(0, (1 << sw(i)) - 1));
    end
  endtask

  task automatic req(input int i, input int sel, input bit mode, input bit c);
    idle_inputs();
    v[i] = 1'b1; s[i] = sel; md[i] = mode; cl[i] = c;
    tick();
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    idle_inputs();
    for (int i = 0; i < NI; i++) begin m_line[i] = -1; m_left[i] = 0; end
    apply();
    repeat (2) @(negedge clk);
    check_all();
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    tick();

    // Pulse on line 2, then level lines 3 -> 1, then release.
    req(0, 2, 1'b0, 1'b0);
    idle_inputs(); repeat (6) tick();
    req(0, 3, 1'b1, 1'b0);
    idle_inputs(); repeat (20) tick();
    req(0, 1, 1'b1, 1'b0);
    idle_inputs(); tick();
    idle_inputs(); cl[0] = 1'b1; tick();
    idle_inputs(); tick();

    // HOLD on line 0 converted to a pulse on line 1.
    req(0, 0, 1'b1, 1'b0);
    req(0, 1, 1'b0, 1'b0);
    idle_inputs(); repeat (6) tick();

    // Abort in the second pulse cycle together with a new request.
    req(0, 2, 1'b0, 1'b0);
    idle_inputs(); tick();
    req(0, 3, 1'b1, 1'b1);
    idle_inputs(); repeat (3) tick();

    // Single-cycle strobes walking every line of the 16-line decoder.
    for (int k = 0; k < 16; k++) begin
      req(2, k, 1'b0, 1'b0);
      idle_inputs(); tick();
    end

    // Asynchronous reset mid-pulse on the active-low instance.
    req(1, 1, 1'b0, 1'b0);
    idle_inputs(); tick();
    apply();
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #2;
    rst_n1 = 1'b0;
    #1;
    check("u1.async_dout",  32'(if1.dout), 32'h0000000F);
    check("u1.async_ready", 32'(if1.in_ready), 32'd0);
    m_line[1] = -1; m_left[1] = 0;
    @(negedge clk);
    check_all();
    tick();
    rst_n1 = 1'b1;
    tick();
    req(1, 0, 1'b0, 1'b0);
    idle_inputs(); repeat (6) tick();

    repeat (1500) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
